reorder_buffer: RTL
===================

# reorder_buffer

In-order retirement unit on the consumer side of the CDB. It allocates one entry per dispatched instruction and returns the RoB index that tags the instruction in the RS and LSB. It captures results broadcast by the RS and LSB, retires at most one entry per cycle from the head, and detects control-flow mispredicts at commit. On a mispredict it drives the global flush (`RoBRS_pre_judge` low) and redirects fetch.

## Interface
- `ADDR_WIDTH`, 32, PC width
- `RoB_WIDTH`, 3, index width; `RoB_SIZE = 1 << RoB_WIDTH`
- `EX_RoB_WIDTH`, `RoB_WIDTH+1`, tag width; `NON_DEP = 1 << RoB_WIDTH` means no dependency
- Opcode encodings: jal=3, jalr=4, beq..bgeu=5..10, sb/sh/sw=16..18
- `Sys_clk` in 1: the single clock; all state updates on its rising edge
- `Sys_rst_n` in 1: asynchronous, active-low reset
- `Sys_rdy` in 1: state advances only when high
- `DPRoB_en` in 1: allocate an entry this cycle
- `DPRoB_opcode` in 7; `DPRoB_rd` in 5; `DPRoB_pc` in ADDR_WIDTH
- `DPRoB_pred_pc` in ADDR_WIDTH: next PC chosen by fetch
- `RoBDP_index` out RoB_WIDTH: tail index (combinational)
- `RoBDP_full` out 1: count == RoB_SIZE (combinational)
- `DPRoB_Qj`, `DPRoB_Qk` in EX_RoB_WIDTH: operand tag queries
- `RoBDP_Qj_ready`, `RoBDP_Qk_ready` out 1; `RoBDP_Qj_value`, `RoBDP_Qk_value` out 32
- `CDBRoB_RS_en` in 1; `CDBRoB_RS_index` in RoB_WIDTH; `CDBRoB_RS_value` in 32; `CDBRoB_RS_next_pc` in ADDR_WIDTH
- `CDBRoB_LSB_en` in 1; `CDBRoB_LSB_index` in RoB_WIDTH; `CDBRoB_LSB_value` in 32
- `RoBRF_en` out 1; `RoBRF_rd` out 5; `RoBRF_value` out 32; `RoBRF_index` out RoB_WIDTH
- `RoBLSB_commit_en` out 1; `RoBLSB_commit_index` out RoB_WIDTH: store released to memory
- `RoBRS_pre_judge` out 1: 1 = correct, 0 = mispredict flush pulse
- `RoBIF_en` out 1; `RoBIF_pc` out ADDR_WIDTH: fetch redirect

## Operation
- Per-entry state: busy, ready, opcode, rd, value, next_pc, pred_pc. Pointers: head, tail (RoB_WIDTH bits, wrap modulo RoB_SIZE); count (RoB_WIDTH+1 bits).
- **Allocate:** when `DPRoB_en && !RoBDP_full`, write the tail entry, set busy, advance tail. ready=1 at allocation for sb/sh/sw; ready=0 otherwise.
- **Writeback:** a CDB port with en set on a busy entry sets ready and stores value (RS also stores next_pc). RS and LSB writes in the same cycle to different indices are both applied. A write to a non-busy entry is ignored.
- **Query:** ready = (tag != NON_DEP) and (entry ready, or a same-cycle CDB port matches the tag). Value comes from the CDB if it matches, else from the entry.
- **Commit:** one entry per cycle, when the head entry is busy and ready. Clear busy and advance head.
  - `RoBRF_en` pulses for non-branch, non-store opcodes with rd != 0.
  - Stores pulse `RoBLSB_commit_en`.
- **Mispredict:** jal, jalr, or branch with next_pc != pred_pc.
  - RF write still occurs (jal/jalr).
  - Same edge: `RoBRS_pre_judge` <= 0, `RoBIF_en` <= 1, `RoBIF_pc` <= next_pc.
  - All busy bits cleared; head = tail = count = 0.
- **Flush cycle:** while `RoBRS_pre_judge` == 0, dispatch and CDB inputs are ignored and no commit occurs.
- Count updates by +alloc −commit. A simultaneous allocate and commit when full is not possible, since full blocks allocation.

## Timing
- Reset values: `RoBRS_pre_judge`=1. All other outputs 0. All entries not busy; pointers and count 0.
- Pulse outputs (`RoBRF_en`, `RoBLSB_commit_en`, `RoBIF_en`, low `pre_judge`) last exactly one cycle.
- When `Sys_rdy` is low, state holds and pulse outputs are driven 0 (`pre_judge` driven 1).
- Latency: CDB writeback at edge k gives commit outputs valid after edge k+1. A store allocated at edge k commits at edge k+1 if it is at the head.
- Asserting reset mid-flush returns the block to reset values immediately.

## Test plan
- Reset then idle → `RoBDP_full`=0, `RoBDP_index`=0, `pre_judge`=1, no commit pulses.
- Allocate 8 addi (rd=1..8) → full=1 after the 8th, and a 9th `DPRoB_en` is ignored. RS writebacks to indices 7..0 produce commits rd=1..8 in order, one per cycle.
- Writebacks to index 2 (RS, value 5) and index 3 (LSB, value 9) in the same cycle → both captured. Queries on tags 2/3 that same cycle return ready with values 5/9.
- beq with pred_pc=0x104, RS next_pc=0x200 → at commit: `pre_judge`=0 for 1 cycle, `RoBIF_pc`=0x200, full=0, index=0. A `DPRoB_en` during the flush cycle is ignored.
- jal rd=1, pc=0x10, pred 0x40, next_pc 0x40 → `RoBRF_en`, value 0x14, no flush.
- sw allocated at head → `RoBLSB_commit_en` one cycle later with the matching index.

Source files
------------

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Purpose  : In-order retirement buffer: allocates tags, captures CDB results,
//            commits one entry per cycle and flushes on control mispredicts.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int ADDR_WIDTH   = 32,
    parameter int RoB_WIDTH    = 3,
    parameter int EX_RoB_WIDTH = RoB_WIDTH + 1
) (
    input  logic                    Sys_clk,
    input  logic                    Sys_rst_n,
    input  logic                    Sys_rdy,
    input  logic                    DPRoB_en,
    input  logic [6:0]              DPRoB_opcode,
    input  logic [4:0]              DPRoB_rd,
    input  logic [ADDR_WIDTH-1:0]   DPRoB_pc,
    input  logic [ADDR_WIDTH-1:0]   DPRoB_pred_pc,
    output logic [RoB_WIDTH-1:0]    RoBDP_index,
    output logic                    RoBDP_full,
    input  logic [EX_RoB_WIDTH-1:0] DPRoB_Qj,
    input  logic [EX_RoB_WIDTH-1:0] DPRoB_Qk,
    output logic                    RoBDP_Qj_ready,
    output logic                    RoBDP_Qk_ready,
    output logic [31:0]             RoBDP_Qj_value,
    output logic [31:0]             RoBDP_Qk_value,
    input  logic                    CDBRoB_RS_en,
    input  logic [RoB_WIDTH-1:0]    CDBRoB_RS_index,
    input  logic [31:0]             CDBRoB_RS_value,
    input  logic [ADDR_WIDTH-1:0]   CDBRoB_RS_next_pc,
    input  logic                    CDBRoB_LSB_en,
    input  logic [RoB_WIDTH-1:0]    CDBRoB_LSB_index,
    input  logic [31:0]             CDBRoB_LSB_value,
    output logic                    RoBRF_en,
    output logic [4:0]              RoBRF_rd,
    output logic [31:0]             RoBRF_value,
    output logic [RoB_WIDTH-1:0]    RoBRF_index,
    output logic                    RoBLSB_commit_en,
    output logic [RoB_WIDTH-1:0]    RoBLSB_commit_index,
    output logic                    RoBRS_pre_judge,
    output logic                    RoBIF_en,
    output logic [ADDR_WIDTH-1:0]   RoBIF_pc
);

    localparam int                      RoB_SIZE = 1 << RoB_WIDTH;
    localparam logic [EX_RoB_WIDTH-1:0] NON_DEP  = EX_RoB_WIDTH'(RoB_SIZE);
    localparam logic [6:0] c_OP_JAL   = 7'd3;
    localparam logic [6:0] c_OP_JALR  = 7'd4;
    localparam logic [6:0] c_OP_BR_LO = 7'd5;
    localparam logic [6:0] c_OP_BR_HI = 7'd10;
    localparam logic [6:0] c_OP_ST_LO = 7'd16;
    localparam logic [6:0] c_OP_ST_HI = 7'd18;

    logic [RoB_SIZE-1:0]   r_busy;
    logic [RoB_SIZE-1:0]   r_ready;
    logic [6:0]            r_opcode  [RoB_SIZE];
    logic [4:0]            r_rd      [RoB_SIZE];
    logic [31:0]           r_value   [RoB_SIZE];
    logic [ADDR_WIDTH-1:0] r_next_pc [RoB_SIZE];
    logic [ADDR_WIDTH-1:0] r_pred_pc [RoB_SIZE];
    logic [RoB_WIDTH-1:0]  r_head;
    logic [RoB_WIDTH-1:0]  r_tail;
    logic [RoB_WIDTH:0]    r_count;

    logic                 w_active;
    logic                 w_alloc;
    logic                 w_alloc_store;
    logic                 w_commit;
    logic [6:0]           w_head_op;
    logic                 w_head_store;
    logic                 w_head_branch;
    logic                 w_mispredict;
    logic [RoB_WIDTH-1:0] w_qj_idx;
    logic [RoB_WIDTH-1:0] w_qk_idx;
    logic                 w_qj_rs, w_qj_lsb, w_qk_rs, w_qk_lsb;
    logic                 w_unused_pc;

    assign w_unused_pc = ^DPRoB_pc;

    assign RoBDP_index = r_tail;
    assign RoBDP_full  = (r_count == (RoB_WIDTH+1)'(RoB_SIZE));

    // Nothing moves while stalled or during the flush cycle after a mispredict.
    assign w_active      = Sys_rdy && RoBRS_pre_judge;
    assign w_alloc       = w_active && DPRoB_en && !RoBDP_full;
    assign w_alloc_store = (DPRoB_opcode >= c_OP_ST_LO) && (DPRoB_opcode <= c_OP_ST_HI);
    assign w_commit      = w_active && r_busy[r_head] && r_ready[r_head];
    assign w_head_op     = r_opcode[r_head];
    assign w_head_store  = (w_head_op >= c_OP_ST_LO) && (w_head_op <= c_OP_ST_HI);
    assign w_head_branch = (w_head_op >= c_OP_BR_LO) && (w_head_op <= c_OP_BR_HI);
    assign w_mispredict  = w_commit
                         && (w_head_branch || (w_head_op == c_OP_JAL) || (w_head_op == c_OP_JALR))
                         && (r_next_pc[r_head] != r_pred_pc[r_head]);

    // Operand queries forward a same-cycle CDB result ahead of the stored one.
    assign w_qj_idx = DPRoB_Qj[RoB_WIDTH-1:0];
    assign w_qk_idx = DPRoB_Qk[RoB_WIDTH-1:0];
    assign w_qj_rs  = CDBRoB_RS_en  && (CDBRoB_RS_index  == w_qj_idx);
    assign w_qj_lsb = CDBRoB_LSB_en && (CDBRoB_LSB_index == w_qj_idx);
    assign w_qk_rs  = CDBRoB_RS_en  && (CDBRoB_RS_index  == w_qk_idx);
    assign w_qk_lsb = CDBRoB_LSB_en && (CDBRoB_LSB_index == w_qk_idx);

    assign RoBDP_Qj_ready = (DPRoB_Qj != NON_DEP) && (r_ready[w_qj_idx] || w_qj_rs || w_qj_lsb);
    assign RoBDP_Qk_ready = (DPRoB_Qk != NON_DEP) && (r_ready[w_qk_idx] || w_qk_rs || w_qk_lsb);
    assign RoBDP_Qj_value = w_qj_rs ? CDBRoB_RS_value : (w_qj_lsb ? CDBRoB_LSB_value : r_value[w_qj_idx]);
    assign RoBDP_Qk_value = w_qk_rs ? CDBRoB_RS_value : (w_qk_lsb ? CDBRoB_LSB_value : r_value[w_qk_idx]);

    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            r_busy              <= '0;
            r_ready             <= '0;
            r_head              <= '0;
            r_tail              <= '0;
            r_count             <= '0;
            for (int i = 0; i < RoB_SIZE; i++) begin
                r_opcode[i]  <= '0;
                r_rd[i]      <= '0;
                r_value[i]   <= '0;
                r_next_pc[i] <= '0;
                r_pred_pc[i] <= '0;
            end
            RoBRF_en            <= 1'b0;
            RoBRF_rd            <= '0;
            RoBRF_value         <= '0;
            RoBRF_index         <= '0;
            RoBLSB_commit_en    <= 1'b0;
            RoBLSB_commit_index <= '0;
            RoBRS_pre_judge     <= 1'b1;
            RoBIF_en            <= 1'b0;
            RoBIF_pc            <= '0;
        end else begin
            RoBRF_en         <= 1'b0;
            RoBLSB_commit_en <= 1'b0;
            RoBIF_en         <= 1'b0;
            RoBRS_pre_judge  <= 1'b1;
            if (w_active) begin
                if (CDBRoB_RS_en && r_busy[CDBRoB_RS_index]) begin
                    r_ready[CDBRoB_RS_index]   <= 1'b1;
                    r_value[CDBRoB_RS_index]   <= CDBRoB_RS_value;
                    r_next_pc[CDBRoB_RS_index] <= CDBRoB_RS_next_pc;
                end
                if (CDBRoB_LSB_en && r_busy[CDBRoB_LSB_index]) begin
                    r_ready[CDBRoB_LSB_index] <= 1'b1;
                    r_value[CDBRoB_LSB_index] <= CDBRoB_LSB_value;
                end
                if (w_alloc) begin
                    r_busy[r_tail]    <= 1'b1;
                    r_ready[r_tail]   <= w_alloc_store;
                    r_opcode[r_tail]  <= DPRoB_opcode;
                    r_rd[r_tail]      <= DPRoB_rd;
                    r_pred_pc[r_tail] <= DPRoB_pred_pc;
                    r_tail            <= r_tail + 1'b1;
                end
                if (w_commit) begin
                    r_busy[r_head]      <= 1'b0;
                    r_head              <= r_head + 1'b1;
                    RoBRF_en            <= !w_head_branch && !w_head_store && (r_rd[r_head] != 5'd0);
                    RoBRF_rd            <= r_rd[r_head];
                    RoBRF_value         <= r_value[r_head];
                    RoBRF_index         <= r_head;
                    RoBLSB_commit_en    <= w_head_store;
                    RoBLSB_commit_index <= r_head;
                end
                r_count <= r_count + (RoB_WIDTH+1)'(w_alloc) - (RoB_WIDTH+1)'(w_commit);
                // A mispredict discards everything younger, including this cycle's allocation.
                if (w_mispredict) begin
                    r_busy          <= '0;
                    r_head          <= '0;
                    r_tail          <= '0;
                    r_count         <= '0;
                    RoBRS_pre_judge <= 1'b0;
                    RoBIF_en        <= 1'b1;
                    RoBIF_pc        <= r_next_pc[r_head];
                end
            end
        end
    end

endmodule
`default_nettype wire
